cache_fm_ctrl: RTL and testbench
================================

# cache_fm_ctrl

Far-memory (FM) request controller directly downstream of the cache pipe's Q3 FM request output. Buffers fill requests and dirty-evict writebacks in an in-order FIFO and issues them one at a time over a valid/ready FM port. For fills, it waits for the FM read response and returns the cache line plus originating TQ id to the transaction queue. The cache pipe cannot stall, so the block exports an almost-full throttle and a sticky overflow error.

## Interface
- CL_WIDTH, 128: cache-line data width in bits.
- ADRS_WIDTH, 20: cache-line address width.
- TQ_ID_WIDTH, 3: transaction-queue entry id width.
- FIFO_DEPTH, 4: request FIFO entries; power of two, at least 4.
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- req_valid_q3  in  1  FM request from cache pipe; no backpressure.
- req_opcode_q3  in  1  0 = FILL (read), 1 = DIRTY_EVICT (write).
- req_address_q3  in  ADRS_WIDTH  cache-line address.
- req_tq_id_q3  in  TQ_ID_WIDTH  originating TQ entry; meaningful for FILL only.
- req_data_q3  in  CL_WIDTH  evicted line; meaningful for DIRTY_EVICT only.
- fifo_almost_full  out  1  throttle to TQ.
- fm_req_valid  out  1  FM request valid.
- fm_req_ready  in  1  FM accepts the request.
- fm_req_opcode  out  1  head-entry opcode.
- fm_req_address  out  ADRS_WIDTH  head-entry address.
- fm_req_data  out  CL_WIDTH  head-entry data.
- fm_rsp_valid  in  1  FM read data valid; single cycle.
- fm_rsp_data  in  CL_WIDTH  FM read data.
- fill_rsp_valid  out  1  fill response to TQ; single-cycle pulse.
- fill_rsp_tq_id  out  TQ_ID_WIDTH  TQ id of the completed fill.
- fill_rsp_address  out  ADRS_WIDTH  address of the completed fill.
- fill_rsp_data  out  CL_WIDTH  filled line.
- overflow_err  out  1  sticky: a request was dropped.

## Operation
- **FIFO**
  - Entry fields: {opcode, address, tq_id, data}.
  - Read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - count is log2(FIFO_DEPTH)+1 bits.
- **Push** occurs when req_valid_q3 is high and either count < FIFO_DEPTH or a pop happens in the same cycle.
  - Push and pop in the same cycle leaves count unchanged.
  - Push while full with no pop: the request is dropped and overflow_err is set. overflow_err clears only on rst.
- **Pop** occurs on the handshake fm_req_valid & fm_req_ready.
- **fifo_almost_full** = (count >= FIFO_DEPTH-2), registered. This covers the two requests that can still be in flight in pipe stages Q1/Q2.
- **FSM states:** IDLE, SEND, WAIT_RSP, RSP.
  - IDLE: if count != 0, go to SEND.
  - SEND: fm_req_valid = 1 and fm_req_* is driven from the FIFO head. On handshake, go to WAIT_RSP if the opcode is FILL, otherwise go to IDLE.
    - On handshake of a FILL, latch tq_id and address into the pending registers.
    - While fm_req_ready = 0, hold fm_req_valid and all fm_req_* fields stable.
  - WAIT_RSP: on fm_rsp_valid, register fm_rsp_data and go to RSP.
  - RSP: fill_rsp_valid = 1 with the pending tq_id/address and registered data. Next state is IDLE.
- **Spurious response:** fm_rsp_valid outside WAIT_RSP is ignored. No state change and no output.
- **Ordering:** strictly in order, and only one FM request is outstanding at a time.
- **Reset:**
  - FSM returns to IDLE; pointers, count and pending registers clear.
  - Every output is 0: fm_req_valid, fm_req_*, fill_rsp_*, fifo_almost_full, overflow_err.
  - A reset mid-operation discards all queued and outstanding requests. A late fm_rsp_valid after reset is ignored because the FSM is in IDLE.

## Timing
- A request presented at cycle N is written into the FIFO at the end of N.
- Issue latency when the FSM is idle:
  - IDLE observes count != 0 at N+1.
  - fm_req_valid is first high at N+2.
  - With fm_req_ready = 1, the handshake happens at N+2.
- Fill response latency: fm_rsp_valid at cycle M gives fill_rsp_valid high for exactly cycle M+1.
  - The next SEND can start at M+3.
- Back-to-back DIRTY_EVICT throughput with ready = 1: one request every 2 cycles (SEND, IDLE, SEND, …).
- fm_req_* outputs are combinational from the registered FIFO head and the registered state; no input-to-output combinational path.
- fill_rsp_* outputs are registered.

## Test plan
- **Single fill:** FILL addr 0x00ABC, tq_id 5 at cycle 10, fm_req_ready = 1, fm_rsp_valid at 20 with data 0xDEAD…BEEF -> fm_req_valid at 12 with opcode 0; fill_rsp_valid only at 21, tq_id 5, addr 0x00ABC, data 0xDEAD…BEEF.
- **Evict backpressure:** DIRTY_EVICT addr 0x1, data 0x55…55, with fm_req_ready held 0 for 5 cycles -> fm_req_valid and fields stable for all 5 cycles; a single handshake once ready rises; no fill_rsp_valid.
- **Ordering and throttle:** 4 FILLs (tq_id 0..3) on consecutive cycles with fm_req_ready = 0 -> fifo_almost_full rises after the 2nd push; count reaches 4; FM issue order is 0, 1, 2, 3; fill_rsp tq_ids 0, 1, 2, 3.
- **Overflow:** a 5th request while full with no pop -> request dropped and overflow_err = 1 until rst. Separately, a push on the same cycle as a pop while full -> accepted with no error.
- **Spurious and late response:** fm_rsp_valid pulsed in IDLE -> no fill_rsp_valid. Assert rst during WAIT_RSP, then send fm_rsp_valid -> no fill_rsp_valid; all outputs 0 on the cycle after rst.

Source files
------------

// File: rtl/cache_fm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cache_fm_ctrl
// Description : Far-memory request controller. Queues fills and dirty evicts
//               from the Q3 FM request port and issues them one at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_fm_ctrl #(
    parameter int CL_WIDTH    = 128,
    parameter int ADRS_WIDTH  = 20,
    parameter int TQ_ID_WIDTH = 3,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   req_valid_q3,
    input  logic                   req_opcode_q3,
    input  logic [ADRS_WIDTH-1:0]  req_address_q3,
    input  logic [TQ_ID_WIDTH-1:0] req_tq_id_q3,
    input  logic [CL_WIDTH-1:0]    req_data_q3,
    output logic                   fifo_almost_full,

    output logic                   fm_req_valid,
    input  logic                   fm_req_ready,
    output logic                   fm_req_opcode,
    output logic [ADRS_WIDTH-1:0]  fm_req_address,
    output logic [CL_WIDTH-1:0]    fm_req_data,

    input  logic                   fm_rsp_valid,
    input  logic [CL_WIDTH-1:0]    fm_rsp_data,

    output logic                   fill_rsp_valid,
    output logic [TQ_ID_WIDTH-1:0] fill_rsp_tq_id,
    output logic [ADRS_WIDTH-1:0]  fill_rsp_address,
    output logic [CL_WIDTH-1:0]    fill_rsp_data,

    output logic                   overflow_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] c_depth    = CNT_W'(FIFO_DEPTH);
    // Two extra slots absorb requests already in flight in Q1/Q2.
    localparam logic [CNT_W-1:0] c_af_level = CNT_W'(FIFO_DEPTH - 2);
    localparam logic             c_op_fill  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_RSP      = 2'd3
    } state_t;

    state_t                 r_state;

    logic                   r_mem_opcode  [FIFO_DEPTH];
    logic [ADRS_WIDTH-1:0]  r_mem_address [FIFO_DEPTH];
    logic [TQ_ID_WIDTH-1:0] r_mem_tq_id   [FIFO_DEPTH];
    logic [CL_WIDTH-1:0]    r_mem_data    [FIFO_DEPTH];

    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    logic                   r_almost_full;
    logic                   r_overflow;

    logic [TQ_ID_WIDTH-1:0] r_pend_tq_id;
    logic [ADRS_WIDTH-1:0]  r_pend_address;
    logic                   r_fill_valid;
    logic [CL_WIDTH-1:0]    r_fill_data;

    logic                   w_sending;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_push;
    logic                   w_head_opcode;
    logic [CNT_W-1:0]       w_count_next;

    assign w_sending     = (r_state == ST_SEND);
    assign w_pop         = w_sending & fm_req_ready;
    assign w_full        = (r_count == c_depth);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push        = req_valid_q3 & (~w_full | w_pop);
    assign w_head_opcode = r_mem_opcode[r_rd_ptr];

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    // Storage carries no reset; outputs are gated so stale entries never leak.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_opcode[r_wr_ptr]  <= req_opcode_q3;
            r_mem_address[r_wr_ptr] <= req_address_q3;
            r_mem_tq_id[r_wr_ptr]   <= req_tq_id_q3;
            r_mem_data[r_wr_ptr]    <= req_data_q3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (req_valid_q3 && !w_push) begin
                r_overflow <= 1'b1;
            end
            r_count       <= w_count_next;
            r_almost_full <= (w_count_next >= c_af_level);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_pend_tq_id   <= '0;
            r_pend_address <= '0;
            r_fill_valid   <= 1'b0;
            r_fill_data    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_count != '0) begin
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (fm_req_ready) begin
                        if (w_head_opcode == c_op_fill) begin
                            r_pend_tq_id   <= r_mem_tq_id[r_rd_ptr];
                            r_pend_address <= r_mem_address[r_rd_ptr];
                            r_state        <= ST_WAIT_RSP;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_WAIT_RSP: begin
                    if (fm_rsp_valid) begin
                        r_fill_data  <= fm_rsp_data;
                        r_fill_valid <= 1'b1;
                        r_state      <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    r_fill_valid <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_fill_valid <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign fifo_almost_full = r_almost_full;
    assign overflow_err     = r_overflow;

    assign fm_req_valid     = w_sending;
    assign fm_req_opcode    = w_sending & w_head_opcode;
    assign fm_req_address   = w_sending ? r_mem_address[r_rd_ptr] : '0;
    assign fm_req_data      = w_sending ? r_mem_data[r_rd_ptr]    : '0;

    assign fill_rsp_valid   = r_fill_valid;
    assign fill_rsp_tq_id   = r_pend_tq_id;
    assign fill_rsp_address = r_pend_address;
    assign fill_rsp_data    = r_fill_data;

    a_req_stable : assert property (@(posedge clk) disable iff (rst)
        (fm_req_valid && !fm_req_ready) |=>
            (fm_req_valid && $stable({fm_req_opcode, fm_req_address, fm_req_data})));

    a_count_range : assert property (@(posedge clk) disable iff (rst)
        (r_count <= c_depth));

    a_fill_pulse : assert property (@(posedge clk) disable iff (rst)
        fill_rsp_valid |=> !fill_rsp_valid);

endmodule
`default_nettype wire

// File: tb/tb_cache_fm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_fm_ctrl
// Description : Directed scenarios plus randomized traffic against a
//               transaction-level queue model of the FM request controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_fm_ctrl;

    localparam int CLW   = 128;
    localparam int AW    = 20;
    localparam int IDW   = 3;
    localparam int DEPTH = 4;

    localparam logic [CLW-1:0] c_dead_beef = 128'hDEAD_0123_4567_89AB_CDEF_FEDC_BA98_BEEF;
    localparam logic [CLW-1:0] c_fives     = {4{32'h5555_5555}};

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid_q3;
    logic           req_opcode_q3;
    logic [AW-1:0]  req_address_q3;
    logic [IDW-1:0] req_tq_id_q3;
    logic [CLW-1:0] req_data_q3;
    logic           fifo_almost_full;
    logic           fm_req_valid;
    logic           fm_req_ready;
    logic           fm_req_opcode;
    logic [AW-1:0]  fm_req_address;
    logic [CLW-1:0] fm_req_data;
    logic           fm_rsp_valid;
    logic [CLW-1:0] fm_rsp_data;
    logic           fill_rsp_valid;
    logic [IDW-1:0] fill_rsp_tq_id;
    logic [AW-1:0]  fill_rsp_address;
    logic [CLW-1:0] fill_rsp_data;
    logic           overflow_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic           op;
        logic [AW-1:0]  addr;
        logic [IDW-1:0] id;
        logic [CLW-1:0] data;
        int             pcyc;
    } ent_t;

    always #5 clk = ~clk;

    cache_fm_ctrl #(
        .CL_WIDTH    (CLW),
        .ADRS_WIDTH  (AW),
        .TQ_ID_WIDTH (IDW),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid_q3     (req_valid_q3),
        .req_opcode_q3    (req_opcode_q3),
        .req_address_q3   (req_address_q3),
        .req_tq_id_q3     (req_tq_id_q3),
        .req_data_q3      (req_data_q3),
        .fifo_almost_full (fifo_almost_full),
        .fm_req_valid     (fm_req_valid),
        .fm_req_ready     (fm_req_ready),
        .fm_req_opcode    (fm_req_opcode),
        .fm_req_address   (fm_req_address),
        .fm_req_data      (fm_req_data),
        .fm_rsp_valid     (fm_rsp_valid),
        .fm_rsp_data      (fm_rsp_data),
        .fill_rsp_valid   (fill_rsp_valid),
        .fill_rsp_tq_id   (fill_rsp_tq_id),
        .fill_rsp_address (fill_rsp_address),
        .fill_rsp_data    (fill_rsp_data),
        .overflow_err     (overflow_err)
    );

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs;
        req_valid_q3   = 1'b0;
        req_opcode_q3  = 1'b0;
        req_address_q3 = '0;
        req_tq_id_q3   = '0;
        req_data_q3    = '0;
        fm_req_ready   = 1'b0;
        fm_rsp_valid   = 1'b0;
        fm_rsp_data    = '0;
    endtask

    // Leaves the bench at a negedge in the first post-reset cycle (cycle 0).
    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [CLW-1:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        checks++;
        if ({fm_req_valid, fm_req_opcode, fm_req_address, fm_req_data} !== '0)
            $display("FAIL reset_fm_req got %h exp 0",
                     {fm_req_valid, fm_req_opcode, fm_req_address, fm_req_data});
        checks++;
        if ({fill_rsp_valid, fill_rsp_tq_id, fill_rsp_address, fill_rsp_data} !== '0)
            $display("FAIL reset_fill_rsp got %h exp 0",
                     {fill_rsp_valid, fill_rsp_tq_id, fill_rsp_address, fill_rsp_data});
        checks++;
        if ({fifo_almost_full, overflow_err} !== 2'b00)
            $display("FAIL reset_flags got %b exp 00", {fifo_almost_full, overflow_err});
        rst = 1'b0;
    endtask

    task automatic test_single_fill;
        do_reset();
        for (int k = 0; k <= 13; k++) begin
            req_valid_q3   = (k == 0);
            req_opcode_q3  = 1'b0;
            req_address_q3 = 20'h00ABC;
            req_tq_id_q3   = 3'd5;
            fm_req_ready   = 1'b1;
            fm_rsp_valid   = (k == 10);
            fm_rsp_data    = c_dead_beef;
            checks++;
            if (fm_req_valid !== (k == 2)) begin
                errors++;
                $display("FAIL fill_req_valid cyc %0d got %b exp %b", k, fm_req_valid, (k == 2));
            end
            if (k == 2) begin
                checks++;
                if ({fm_req_opcode, fm_req_address} !== {1'b0, 20'h00ABC}) begin
                    errors++;
                    $display("FAIL fill_req_fields got %h exp %h",
                             {fm_req_opcode, fm_req_address}, {1'b0, 20'h00ABC});
                end
            end
            checks++;
            if (fill_rsp_valid !== (k == 11)) begin
                errors++;
                $display("FAIL fill_rsp_valid cyc %0d got %b exp %b", k, fill_rsp_valid, (k == 11));
            end
            if (k == 11) begin
                checks++;
                if ({fill_rsp_tq_id, fill_rsp_address, fill_rsp_data} !== {3'd5, 20'h00ABC, c_dead_beef}) begin
                    errors++;
                    $display("FAIL fill_rsp_fields got %h exp %h",
                             {fill_rsp_tq_id, fill_rsp_address, fill_rsp_data},
                             {3'd5, 20'h00ABC, c_dead_beef});
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_evict_backpressure;
        int hs = 0;
        bit exp_v;
        do_reset();
        for (int k = 0; k <= 11; k++) begin
            req_valid_q3   = (k == 0);
            req_opcode_q3  = 1'b1;
            req_address_q3 = 20'h00001;
            req_data_q3    = c_fives;
            fm_req_ready   = (k >= 7);
            exp_v          = (k >= 2) && (k <= 7);
            checks++;
            if (fm_req_valid !== exp_v) begin
                errors++;
                $display("FAIL evict_valid cyc %0d got %b exp %b", k, fm_req_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if ({fm_req_opcode, fm_req_address, fm_req_data} !== {1'b1, 20'h00001, c_fives}) begin
                    errors++;
                    $display("FAIL evict_stable cyc %0d got %h exp %h", k,
                             {fm_req_opcode, fm_req_address, fm_req_data}, {1'b1, 20'h00001, c_fives});
                end
            end
            checks++;
            if (fill_rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL evict_no_fill cyc %0d got %b exp 0", k, fill_rsp_valid);
            end
            if (fm_req_valid && fm_req_ready) hs++;
            tick();
        end
        checks++;
        if (hs != 1) begin
            errors++;
            $display("FAIL evict_handshakes got %0d exp 1", hs);
        end
        idle_inputs();
    endtask

    task automatic test_order_throttle;
        logic [CLW-1:0] d;
        bit found;
        do_reset();
        for (int k = 0; k <= 5; k++) begin
            req_valid_q3   = (k < 4);
            req_opcode_q3  = 1'b0;
            req_address_q3 = AW'(32'h100 + k);
            req_tq_id_q3   = IDW'(k);
            fm_req_ready   = 1'b0;
            checks++;
            if (fifo_almost_full !== (k >= 2)) begin
                errors++;
                $display("FAIL throttle_af cyc %0d got %b exp %b", k, fifo_almost_full, (k >= 2));
            end
            tick();
        end
        req_valid_q3 = 1'b0;
        checks++;
        if (overflow_err !== 1'b0) begin
            errors++;
            $display("FAIL throttle_no_ovf got %b exp 0", overflow_err);
        end
        for (int i = 0; i < 4; i++) begin
            fm_req_ready = 1'b1;
            found = 1'b0;
            for (int w = 0; w < 20 && !found; w++) begin
                if (fm_req_valid) found = 1'b1;
                else tick();
            end
            checks++;
            if (!found) begin
                errors++;
                $display("FAIL order_timeout req %0d got none exp valid", i);
            end else begin
                if ({fm_req_opcode, fm_req_address} !== {1'b0, AW'(32'h100 + i)}) begin
                    errors++;
                    $display("FAIL order_issue got %h exp %h",
                             {fm_req_opcode, fm_req_address}, {1'b0, AW'(32'h100 + i)});
                end
                tick();
                fm_req_ready = 1'b0;
                tick();
                d            = rand_line();
                fm_rsp_valid = 1'b1;
                fm_rsp_data  = d;
                tick();
                fm_rsp_valid = 1'b0;
                checks++;
                if ({fill_rsp_valid, fill_rsp_tq_id, fill_rsp_address, fill_rsp_data} !==
                    {1'b1, IDW'(i), AW'(32'h100 + i), d}) begin
                    errors++;
                    $display("FAIL order_fill got %h exp %h",
                             {fill_rsp_valid, fill_rsp_tq_id, fill_rsp_address, fill_rsp_data},
                             {1'b1, IDW'(i), AW'(32'h100 + i), d});
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_overflow;
        int hs = 0;
        logic [AW-1:0] got [$];
        do_reset();
        for (int k = 0; k <= 15; k++) begin
            req_valid_q3   = (k <= 4);
            req_opcode_q3  = 1'b1;
            req_address_q3 = AW'(32'h200 + k);
            fm_req_ready   = (k >= 6);
            if (k == 4 || k == 5) begin
                checks++;
                if (overflow_err !== (k == 5)) begin
                    errors++;
                    $display("FAIL ovf_set cyc %0d got %b exp %b", k, overflow_err, (k == 5));
                end
            end
            if (fm_req_valid && fm_req_ready) hs++;
            tick();
        end
        checks++;
        if (hs != 4 || overflow_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drop got hs=%0d ovf=%b exp hs=4 ovf=1", hs, overflow_err);
        end
        do_reset();
        checks++;
        if (overflow_err !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got %b exp 0", overflow_err);
        end
        for (int k = 0; k <= 20; k++) begin
            req_valid_q3   = (k < 4) || (k == 5);
            req_opcode_q3  = 1'b1;
            req_address_q3 = AW'(32'h300 + ((k < 4) ? k : 4));
            fm_req_ready   = (k >= 5);
            if (fm_req_valid && fm_req_ready) got.push_back(fm_req_address);
            tick();
        end
        checks++;
        if (overflow_err !== 1'b0) begin
            errors++;
            $display("FAIL ovf_pop_push got %b exp 0", overflow_err);
        end
        checks++;
        if (got.size() != 5) begin
            errors++;
            $display("FAIL ovf_pop_push_count got %0d exp 5", got.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got[i] !== AW'(32'h300 + i)) begin
                    errors++;
                    $display("FAIL ovf_pop_push_order idx %0d got %h exp %h", i, got[i], AW'(32'h300 + i));
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_spurious_late;
        do_reset();
        for (int k = 0; k <= 3; k++) begin
            fm_rsp_valid = (k == 0);
            fm_rsp_data  = c_dead_beef;
            checks++;
            if ({fill_rsp_valid, fm_req_valid} !== 2'b00) begin
                errors++;
                $display("FAIL spurious cyc %0d got %b exp 00", k, {fill_rsp_valid, fm_req_valid});
            end
            tick();
        end
        for (int k = 0; k <= 3; k++) begin
            req_valid_q3   = (k == 0);
            req_opcode_q3  = 1'b0;
            req_address_q3 = 20'h00777;
            req_tq_id_q3   = 3'd6;
            fm_req_ready   = 1'b1;
            fm_rsp_valid   = 1'b0;
            tick();
        end
        checks++;
        if (fm_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL late_wait_state got %b exp 0", fm_req_valid);
        end
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fm_rsp_valid = 1'b1;
        fm_rsp_data  = c_dead_beef;
        checks++;
        if ({fm_req_valid, fm_req_opcode, fm_req_address, fm_req_data, fill_rsp_valid, fill_rsp_tq_id,
             fill_rsp_address, fill_rsp_data, fifo_almost_full, overflow_err} !== '0) begin
            errors++;
            $display("FAIL late_reset_outputs got nonzero exp 0");
        end
        for (int k = 0; k <= 3; k++) begin
            tick();
            fm_rsp_valid = 1'b0;
            checks++;
            if ({fill_rsp_valid, fm_req_valid} !== 2'b00) begin
                errors++;
                $display("FAIL late_rsp cyc %0d got %b exp 00", k, {fill_rsp_valid, fm_req_valid});
            end
        end
        idle_inputs();
    endtask

    // Transaction model: an in-order queue, one outstanding request, and the
    // documented issue/response latencies expressed as earliest-issue cycles.
    task automatic test_random(input int ncyc, input int req_pct, input int rdy_pct);
        ent_t mq[$];
        ent_t e;
        ent_t cur;
        bit sending = 1'b0;
        bit outstanding = 1'b0;
        bit ovf = 1'b0;
        bit pop, push;
        int next_ok = 0;
        int fill_cyc = -1;
        logic [CLW-1:0] fill_data = '0;
        do_reset();
        for (int c = 0; c < ncyc; c++) begin
            if (!sending && !outstanding && c >= next_ok && mq.size() > 0 && mq[0].pcyc <= c - 2)
                sending = 1'b1;
            checks++;
            if (fm_req_valid !== sending) begin
                errors++;
                $display("FAIL rand_req_valid cyc %0d got %b exp %b", c, fm_req_valid, sending);
            end
            if (sending) begin
                checks++;
                if ({fm_req_opcode, fm_req_address, fm_req_data} !== {mq[0].op, mq[0].addr, mq[0].data}) begin
                    errors++;
                    $display("FAIL rand_req_fields cyc %0d got %h exp %h", c,
                             {fm_req_opcode, fm_req_address}, {mq[0].op, mq[0].addr});
                end
            end
            checks++;
            if (fill_rsp_valid !== (c == fill_cyc)) begin
                errors++;
                $display("FAIL rand_fill_valid cyc %0d got %b exp %b", c, fill_rsp_valid, (c == fill_cyc));
            end
            if (c == fill_cyc) begin
                checks++;
                if ({fill_rsp_tq_id, fill_rsp_address, fill_rsp_data} !== {cur.id, cur.addr, fill_data}) begin
                    errors++;
                    $display("FAIL rand_fill_fields cyc %0d got %h exp %h", c,
                             {fill_rsp_tq_id, fill_rsp_address}, {cur.id, cur.addr});
                end
            end
            checks++;
            if (fifo_almost_full !== (mq.size() >= DEPTH - 2)) begin
                errors++;
                $display("FAIL rand_af cyc %0d got %b exp %b", c, fifo_almost_full, (mq.size() >= DEPTH - 2));
            end
            checks++;
            if (overflow_err !== ovf) begin
                errors++;
                $display("FAIL rand_ovf cyc %0d got %b exp %b", c, overflow_err, ovf);
            end

            req_valid_q3   = ($urandom_range(0, 99) < req_pct);
            req_opcode_q3  = 1'($urandom_range(0, 1));
            req_address_q3 = AW'($urandom());
            req_tq_id_q3   = IDW'($urandom());
            req_data_q3    = rand_line();
            fm_req_ready   = ($urandom_range(0, 99) < rdy_pct);
            fm_rsp_valid   = ($urandom_range(0, 99) < 30);
            fm_rsp_data    = rand_line();

            if (outstanding && fm_rsp_valid) begin
                outstanding = 1'b0;
                fill_cyc    = c + 1;
                fill_data   = fm_rsp_data;
                next_ok     = c + 3;
            end
            pop  = sending && fm_req_ready;
            push = req_valid_q3 && (mq.size() < DEPTH || pop);
            if (req_valid_q3 && !push) ovf = 1'b1;
            if (pop) begin
                e = mq.pop_front();
                sending = 1'b0;
                if (e.op == 1'b0) begin
                    outstanding = 1'b1;
                    cur = e;
                end else begin
                    next_ok = c + 2;
                end
            end
            if (push) begin
                e.op   = req_opcode_q3;
                e.addr = req_address_q3;
                e.id   = req_tq_id_q3;
                e.data = req_data_q3;
                e.pcyc = c;
                mq.push_back(e);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_fill();
        test_evict_backpressure();
        test_order_throttle();
        test_overflow();
        test_spurious_late();
        test_random(600, 25, 70);
        test_random(600, 55, 40);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
